// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
//   Shared definitions for the data-memory arbiter: FSM state encoding,
//   access size codes, default cache window and the size -> byte-count lookup.
//   The default cache window is overridden through the CACHE_OFFSET and
//   CACHE_SIZE parameters of dmem_arbiter.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    localparam logic [31:0] DEF_CACHE_OFFSET = 32'h0000_1000;
    localparam logic [31:0] DEF_CACHE_SIZE   = 32'h0000_00FF;

    // Reserved size reports one byte so the range arithmetic never
    // underflows; the reserved code is rejected separately.
    function automatic logic [2:0] sz_nbytes(input logic [1:0] sz);
        case (sz)
            SZ_H:    sz_nbytes = 3'd2;
            SZ_W:    sz_nbytes = 3'd4;
            default: sz_nbytes = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the two requester ports and the data-cache port of dmem_arbiter.
//   Requester fields are packed {p1,p0}.
//   slave  : the arbiter (consumes i_*, drives o_*)
//   master : requesters plus cache model (drive i_*, consume o_*)
interface dmem_arbiter_if;
    logic [1:0]  i_req;
    logic [1:0]  i_we;
    logic [3:0]  i_size;
    logic [1:0]  i_unsigned;
    logic [63:0] i_addr;
    logic [63:0] i_wdata;
    logic [1:0]  o_gnt;
    logic [1:0]  o_done;
    logic        o_err;
    logic [31:0] o_rdata;
    logic        o_busy;
    logic [31:0] o_mem_addr;
    logic [7:0]  o_mem_wdata;
    logic        o_mem_we;
    logic        o_mem_re;
    logic [31:0] i_mem_rdata;

    modport slave (
        input  i_req, i_we, i_size, i_unsigned, i_addr, i_wdata, i_mem_rdata,
        output o_gnt, o_done, o_err, o_rdata, o_busy,
               o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re
    );

    modport master (
        output i_req, i_we, i_size, i_unsigned, i_addr, i_wdata, i_mem_rdata,
        input  o_gnt, o_done, o_err, o_rdata, o_busy,
               o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re
    );
endinterface

// File: rtl/dmem_arbiter_load_align.sv
// dmem_load_align
//   Combinational load formatter. The cache returns bytes addr+3..addr, so the
//   addressed lane is always the low end; keep the low 1/2/4 bytes and
//   sign- or zero-extend to 32 bits.
//   rdata_i    in  32  raw cache word
//   size_i     in  2   size code (reserved code yields 0)
//   unsigned_i in  1   1 = zero-extend, 0 = sign-extend
//   data_o     out 32  formatted load value
module dmem_load_align
    import dmem_arbiter_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);
    always_comb begin
        case (size_i)
            SZ_B:    data_o = {{24{rdata_i[7]  & ~unsigned_i}}, rdata_i[7:0]};
            SZ_H:    data_o = {{16{rdata_i[15] & ~unsigned_i}}, rdata_i[15:0]};
            SZ_W:    data_o = rdata_i;
            default: data_o = 32'h0;
        endcase
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Round-robin arbiter sharing the byte-addressed data cache between port 0
//   (core LSU) and port 1 (loader/debug). One transaction outstanding; loads
//   take one read cycle, stores write one byte per cycle.
//   Optional feature: define DMEM_ARB_MISALIGN_TRAP_EN to reject misaligned
//   half/word accesses with o_err instead of performing them.
//   i_clk, i_rst  clock (rising edge) and async active-high reset
//   bus (slave)   requester handshake {p1,p0}, status outputs, cache port
//
//   state | meaning
//   IDLE  | waiting; accepts a request (may coincide with o_done)
//   RD    | single cache read cycle, result captured at its end
//   WR    | one byte written per cycle, cnt = byte index
//   FIN   | rejected request, no cache access, completes with o_err
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter logic [31:0] CACHE_OFFSET = DEF_CACHE_OFFSET,
    parameter logic [31:0] CACHE_SIZE   = DEF_CACHE_SIZE
) (
    input logic           i_clk,
    input logic           i_rst,
    dmem_arbiter_if.slave bus
);
    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        rr_last_q;
    logic        port_q, we_q, uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;

    logic [1:0]  gnt_q, gnt_d, done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    // ---- request selection and legality (combinational, used in IDLE) ----
    logic        any_req, win, sel_we;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;
    logic [2:0]  sel_nb;
    logic [32:0] sel_last, cache_end;
    logic        align_ok, sel_legal, accept;

    assign any_req  = |bus.i_req;
    assign win      = (bus.i_req == 2'b11) ? ~rr_last_q : bus.i_req[1];
    assign sel_we   = bus.i_we[win];
    assign sel_size = win ? bus.i_size[3:2]  : bus.i_size[1:0];
    assign sel_addr = win ? bus.i_addr[63:32] : bus.i_addr[31:0];
    assign sel_nb   = sz_nbytes(sel_size);

    // 33-bit sums so an access near 0xFFFFFFFF cannot wrap into range.
    assign sel_last  = {1'b0, sel_addr} + {30'b0, sel_nb} - 33'd1;
    assign cache_end = {1'b0, CACHE_OFFSET} + {1'b0, CACHE_SIZE};

`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    assign align_ok = !((sel_size == SZ_H && sel_addr[0]) ||
                        (sel_size == SZ_W && sel_addr[1:0] != 2'b00));
`else
    assign align_ok = 1'b1;
`endif

    assign sel_legal = (sel_size != SZ_RSV) && (sel_addr >= CACHE_OFFSET) &&
                       (sel_last <= cache_end) && align_ok;
    assign accept    = (state_q == ST_IDLE) && any_req;

    // ---- latched transaction ----
    logic [2:0]  nb_q;
    logic        wr_last;
    logic [31:0] load_val;

    assign nb_q    = sz_nbytes(size_q);
    assign wr_last = (state_q == ST_WR) && ({1'b0, cnt_q} == nb_q - 3'd1);

    dmem_load_align u_align (
        .rdata_i    (bus.i_mem_rdata),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (load_val)
    );

    // ---- FSM: state register ----
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---- FSM: next state ----
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    cnt_d = 2'd0;
                    if (!sel_legal)  state_d = ST_FIN;
                    else if (sel_we) state_d = ST_WR;
                    else             state_d = ST_RD;
                end
            end
            ST_RD:  state_d = ST_IDLE;
            ST_WR: begin
                if (wr_last) begin
                    state_d = ST_IDLE;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    logic finishing;

    always_comb begin
        finishing = (state_q == ST_RD) || (state_q == ST_FIN) || wr_last;

        bus.o_mem_re    = (state_q == ST_RD);
        bus.o_mem_we    = (state_q == ST_WR);
        bus.o_mem_addr  = 32'h0;
        bus.o_mem_wdata = 8'h0;
        if (state_q == ST_RD) begin
            bus.o_mem_addr = addr_q;
        end else if (state_q == ST_WR) begin
            bus.o_mem_addr  = addr_q + {30'b0, cnt_q};
            bus.o_mem_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
        end

        gnt_d   = accept ? (win ? 2'b10 : 2'b01) : 2'b00;
        done_d  = finishing ? (port_q ? 2'b10 : 2'b01) : 2'b00;
        err_d   = (state_q == ST_FIN);
        rdata_d = rdata_q;
        if (finishing) rdata_d = (state_q == ST_RD) ? load_val : 32'h0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // ---- arbitration pointer and request capture ----
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_last_q <= 1'b1;
            port_q    <= 1'b0;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            size_q    <= SZ_B;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
        end else if (accept) begin
            rr_last_q <= win;
            port_q    <= win;
            we_q      <= sel_we;
            uns_q     <= bus.i_unsigned[win];
            size_q    <= sel_size;
            addr_q    <= sel_addr;
            wdata_q   <= win ? bus.i_wdata[63:32] : bus.i_wdata[31:0];
        end
    end

    assign bus.o_gnt   = gnt_q;
    assign bus.o_done  = done_q;
    assign bus.o_err   = err_q;
    assign bus.o_rdata = rdata_q;
    assign bus.o_busy  = (state_q != ST_IDLE);

    // Direction is implied by the state; the latched flag is kept for
    // debug visibility only.
    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed + randomized bench for dmem_arbiter. A byte-array cache model
//   answers reads and absorbs writes; a reference model computes load values,
//   legality and latencies from the access rules with plain arithmetic.
module tb_dmem_arbiter;
    localparam logic [31:0] OFF = 32'h0000_1000;
    localparam logic [31:0] CSZ = 32'h0000_00FF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if bus ();
    dmem_arbiter #(.CACHE_OFFSET(OFF), .CACHE_SIZE(CSZ)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // ---- cache model ----
    logic [7:0] cache   [0:255];
    logic [7:0] ref_mem [0:255];
    logic       load_cache = 1'b0;

    always @(posedge clk) begin
        if (load_cache) begin
            for (int i = 0; i < 256; i++) cache[i] <= ref_mem[i];
        end else if (bus.o_mem_we) begin
            cache[bus.o_mem_addr[7:0]] <= bus.o_mem_wdata;
        end
    end

    logic [7:0] ra0, ra1, ra2, ra3;
    assign ra0 = bus.o_mem_addr[7:0];
    assign ra1 = ra0 + 8'd1;
    assign ra2 = ra0 + 8'd2;
    assign ra3 = ra0 + 8'd3;
    assign bus.i_mem_rdata = {cache[ra3], cache[ra2], cache[ra1], cache[ra0]};

    // ---- monitor ----
    int          re_cnt = 0;
    logic [31:0] wq_addr [$];
    logic [7:0]  wq_data [$];
    logic        gnt_log [$];

    always @(negedge clk) begin
        if (bus.o_mem_re) re_cnt <= re_cnt + 1;
        if (bus.o_mem_we) begin
            wq_addr.push_back(bus.o_mem_addr);
            wq_data.push_back(bus.o_mem_wdata);
        end
        if (bus.o_gnt != 2'b00) gnt_log.push_back(bus.o_gnt[1]);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---- helpers ----
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sync_cache();
        load_cache = 1'b1;
        @(posedge clk);
        #1 load_cache = 1'b0;
        @(negedge clk);
    endtask

    task automatic drive_port(input int p, input bit we, input logic [1:0] sz, input bit uns,
                              input logic [31:0] a, input logic [31:0] wd, input bit req);
        bus.i_req[p]            = req;
        bus.i_we[p]             = we;
        bus.i_size[2*p +: 2]    = sz;
        bus.i_unsigned[p]       = uns;
        bus.i_addr[32*p +: 32]  = a;
        bus.i_wdata[32*p +: 32] = wd;
    endtask

    // Reference model: legality, load value, byte count; stores update ref_mem.
    function automatic void model(input bit we, input logic [1:0] sz, input bit uns,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output bit err, output logic [31:0] val, output int n);
        longint lo, hi;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        lo  = longint'({32'h0, a});
        hi  = lo + n - 1;
        err = (sz == 2'd3) || (lo < longint'({32'h0, OFF})) ||
              (hi > longint'({32'h0, OFF}) + longint'({32'h0, CSZ}));
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
        if (sz == 2'd1 && a[0]) err = 1'b1;
        if (sz == 2'd2 && a[1:0] != 2'b00) err = 1'b1;
`endif
        val = 32'h0;
        if (!err) begin
            for (int i = 0; i < n; i++) begin
                if (we) ref_mem[a - OFF + i] = wd[8*i +: 8];
                else    val = val | (32'(ref_mem[a - OFF + i]) << (8*i));
            end
            if (!we && !uns && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
        end
    endfunction

    // Issue on port p starting at a negedge with the DUT idle; return at the done negedge.
    task automatic txn(input int p, input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err,
                       output int glat, output int dlat, output logic gre);
        drive_port(p, we, sz, uns, a, wd, 1'b1);
        glat = 0;
        repeat (20) begin
            @(negedge clk);
            glat++;
            if (bus.o_gnt[p]) break;
        end
        chk("gnt_seen", {31'b0, bus.o_gnt[p]}, 32'd1);
        gre = bus.o_mem_re;
        bus.i_req[p] = 1'b0;
        dlat = glat;
        repeat (20) begin
            @(negedge clk);
            dlat++;
            if (bus.o_done[p]) break;
        end
        chk("done_seen", {31'b0, bus.o_done[p]}, 32'd1);
        rd  = bus.o_rdata;
        err = bus.o_err;
    endtask

    task automatic run_check(input string tag, input int p, input bit we, input logic [1:0] sz,
                             input bit uns, input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] rd, output logic err, output logic gre);
        bit          m_err;
        logic [31:0] m_val;
        int          n, re0, wq0, glat, dlat, exp_dlat;
        model(we, sz, uns, a, wd, m_err, m_val, n);
        re0 = re_cnt;
        wq0 = wq_addr.size();
        txn(p, we, sz, uns, a, wd, rd, err, glat, dlat, gre);
        exp_dlat = (!m_err && we) ? n + 1 : 2;
        chk({tag, ".err"},      {31'b0, err}, {31'b0, m_err});
        chk({tag, ".rdata"},    rd, m_val);
        chk({tag, ".gnt_lat"},  glat, 32'd1);
        chk({tag, ".done_lat"}, dlat, exp_dlat);
        chk({tag, ".reads"},    re_cnt - re0, (!m_err && !we) ? 32'd1 : 32'd0);
        chk({tag, ".writes"},   wq_addr.size() - wq0, (!m_err && we) ? n : 0);
        if (!m_err && we) begin
            for (int i = 0; i < n; i++) begin
                if (wq0 + i < wq_addr.size()) begin
                    chk({tag, ".waddr"}, wq_addr[wq0 + i], a + i);
                    chk({tag, ".wbyte"}, {24'h0, wq_data[wq0 + i]}, {24'h0, wd[8*i +: 8]});
                end
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".gnt"},   {30'b0, bus.o_gnt}, 32'd0);
        chk({tag, ".done"},  {30'b0, bus.o_done}, 32'd0);
        chk({tag, ".err"},   {31'b0, bus.o_err}, 32'd0);
        chk({tag, ".rdata"}, bus.o_rdata, 32'd0);
        chk({tag, ".busy"},  {31'b0, bus.o_busy}, 32'd0);
        chk({tag, ".re"},    {31'b0, bus.o_mem_re}, 32'd0);
        chk({tag, ".we"},    {31'b0, bus.o_mem_we}, 32'd0);
        chk({tag, ".maddr"}, bus.o_mem_addr, 32'd0);
        chk({tag, ".wdata"}, {24'h0, bus.o_mem_wdata}, 32'd0);
    endtask

    // ---- stimulus ----
    logic [31:0] rd, A, a, wd, m_val;
    logic        err, gre;
    bit          m_err;
    int          n, g0, p;
    logic        done_seen;

    initial begin
        bus.i_req = '0; bus.i_we = '0; bus.i_size = '0; bus.i_unsigned = '0;
        bus.i_addr = '0; bus.i_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);

        // 1: reset state, then LW 0xDEADBEEF
        ref_mem[8'h10] = 8'hEF; ref_mem[8'h11] = 8'hBE;
        ref_mem[8'h12] = 8'hAD; ref_mem[8'h13] = 8'hDE;
        sync_cache();
        @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        run_check("lw_dead", 0, 1'b0, 2'd2, 1'b0, OFF + 32'h10, 32'h0, rd, err, gre);
        chk("lw_dead.value", rd, 32'hDEAD_BEEF);
        chk("lw_dead.re_at_gnt", {31'b0, gre}, 32'd1);

        // 2: byte / half sign and zero extension
        ref_mem[8'h20] = 8'h80; ref_mem[8'h22] = 8'h01; ref_mem[8'h23] = 8'h80;
        sync_cache();
        run_check("lb",  0, 1'b0, 2'd0, 1'b0, OFF + 32'h20, 32'h0, rd, err, gre);
        chk("lb.value", rd, 32'hFFFF_FF80);
        run_check("lbu", 0, 1'b0, 2'd0, 1'b1, OFF + 32'h20, 32'h0, rd, err, gre);
        chk("lbu.value", rd, 32'h0000_0080);
        run_check("lh",  1, 1'b0, 2'd1, 1'b0, OFF + 32'h22, 32'h0, rd, err, gre);
        chk("lh.value", rd, 32'hFFFF_8001);
        run_check("lhu", 1, 1'b0, 2'd1, 1'b1, OFF + 32'h22, 32'h0, rd, err, gre);
        chk("lhu.value", rd, 32'h0000_8001);

        // 3: p1 SW then read back
        A = OFF + 32'h40;
        run_check("sw_p1", 1, 1'b1, 2'd2, 1'b0, A, 32'h1122_3344, rd, err, gre);
        run_check("lw_back", 0, 1'b0, 2'd2, 1'b0, A, 32'h0, rd, err, gre);
        chk("lw_back.value", rd, 32'h1122_3344);

        // 4a: both requests held from reset -> 0,1,0,1
        @(negedge clk);
        rst = 1'b1;
        drive_port(0, 1'b0, 2'd2, 1'b0, OFF + 32'h10, 32'h0, 1'b1);
        drive_port(1, 1'b0, 2'd2, 1'b0, A, 32'h0, 1'b1);
        @(negedge clk);
        g0 = gnt_log.size();
        rst = 1'b0;
        repeat (9) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("rr_order", (g0 + i < gnt_log.size()) ? {31'b0, gnt_log[g0 + i]} : 32'hFFFF_FFFF,
                32'(i % 2));
        end
        bus.i_req = 2'b00;
        repeat (4) @(negedge clk);

        // 4b: p1 arrives during a p0 SW, granted right after the SW's done cycle
        wd = $urandom;
        model(1'b1, 2'd2, 1'b0, OFF + 32'h50, wd, m_err, m_val, n);
        drive_port(0, 1'b1, 2'd2, 1'b0, OFF + 32'h50, wd, 1'b1);
        repeat (20) begin @(negedge clk); if (bus.o_gnt[0]) break; end
        chk("rr_b.gnt0", {30'b0, bus.o_gnt}, 32'd1);
        bus.i_req[0] = 1'b0;
        @(negedge clk);
        model(1'b0, 2'd2, 1'b0, OFF + 32'h10, 32'h0, m_err, m_val, n);
        drive_port(1, 1'b0, 2'd2, 1'b0, OFF + 32'h10, 32'h0, 1'b1);
        repeat (20) begin @(negedge clk); if (bus.o_done[0]) break; end
        chk("rr_b.done0", {30'b0, bus.o_done}, 32'd1);
        @(negedge clk);
        chk("rr_b.gnt1_after_done", {30'b0, bus.o_gnt}, 32'd2);
        bus.i_req[1] = 1'b0;
        repeat (20) begin @(negedge clk); if (bus.o_done[1]) break; end
        chk("rr_b.done1", {30'b0, bus.o_done}, 32'd2);
        chk("rr_b.rdata", bus.o_rdata, m_val);

        // 5: rejected requests
        run_check("rsv_size", 0, 1'b0, 2'd3, 1'b0, OFF + 32'h10, 32'h0, rd, err, gre);
        chk("rsv_size.err1", {31'b0, err}, 32'd1);
        run_check("below",    1, 1'b0, 2'd0, 1'b0, OFF - 32'd1, 32'h0, rd, err, gre);
        chk("below.err1", {31'b0, err}, 32'd1);
        run_check("over_end", 0, 1'b1, 2'd2, 1'b0, OFF + CSZ - 32'd1, 32'hCAFE_F00D, rd, err, gre);
        run_check("wrap",     1, 1'b0, 2'd2, 1'b0, 32'hFFFF_FFFF, 32'h0, rd, err, gre);
        run_check("last_ok",  0, 1'b0, 2'd0, 1'b1, OFF + CSZ, 32'h0, rd, err, gre);

        // 6: misaligned word load
        run_check("lw_mis", 0, 1'b0, 2'd2, 1'b0, A + 32'd1, 32'h0, rd, err, gre);
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
        chk("lw_mis.trap", {31'b0, err}, 32'd1);
`else
        chk("lw_mis.low3", rd & 32'h00FF_FFFF, 32'h0011_2233);
`endif

        // random traffic
        for (int it = 0; it < 40; it++) begin
            p = $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = OFF - 32'd3 + $urandom_range(0, 32'(CSZ) + 6);
            run_check("rand", p, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), a, $urandom, rd, err, gre);
        end

        // 7: reset during the third byte of a store
        for (int i = 8'h60; i < 8'h64; i++) ref_mem[i] = 8'hAA;
        sync_cache();
        A = OFF + 32'h60;
        drive_port(0, 1'b1, 2'd2, 1'b0, A, 32'h5566_7788, 1'b1);
        repeat (20) begin @(negedge clk); if (bus.o_gnt[0]) break; end
        bus.i_req[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort.third_byte_addr", bus.o_mem_addr, A + 32'd2);
        rst = 1'b1;
        #1;
        chk_all_zero("abort");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 1'b0;
        repeat (5) begin @(negedge clk); if (bus.o_done != 2'b00) done_seen = 1'b1; end
        chk("abort.no_done", {31'b0, done_seen}, 32'd0);
        chk("abort.byte0", {24'h0, cache[8'h60]}, 32'h88);
        chk("abort.byte1", {24'h0, cache[8'h61]}, 32'h77);
        chk("abort.byte2", {24'h0, cache[8'h62]}, 32'hAA);
        chk("abort.byte3", {24'h0, cache[8'h63]}, 32'hAA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
